// File: rtl/refclk_ce_pkg.sv
// Shared types and helpers for the BUFHCE reference-clock CE sequencer.
// Holds the sequencer state encoding, counter width helper and requester default.
package refclk_ce_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_ENABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_GATED     = 3'd4,
    ST_WAKE      = 3'd5
  } seq_state_e;

  // Width able to hold the largest of the four timing parameters.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/refclk_ce_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
// load and clr both restart the count from load_val.
module refclk_ce_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load || clr) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/refclk_ce_sequencer.sv
// Power-up / clock-gating sequencer driving the CE of a BUFHCE fed from the GTE2 refclk.
// Optional idle gating of the clock is built when REFCLK_CE_IDLE_GATE_EN is defined.
module refclk_ce_sequencer
  import refclk_ce_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned IDLE_CYCLES     = 64,
  parameter int unsigned WAKE_CYCLES     = 4
) (
  input  logic               clk_int,
  input  logic               sys_rst_n,
  input  logic               refclk_valid,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               bufh_ce,
  output logic               user_rst_n,
  output logic [2:0]         seq_state,
  output logic               fault
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES, RST_HOLD_CYCLES, IDLE_CYCLES, WAKE_CYCLES);

  seq_state_e         state_q, state_d;
  logic               ce_q, ce_d;
  logic               urst_q, urst_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               fault_q, fault_d;

  // Shared timer for the mutually exclusive stabilize / hold / wake phases.
  logic          t_load, t_clr, t_dec, t_done;
  logic [CW-1:0] t_val;

  refclk_ce_timer #(.W(CW)) u_seq_timer (
    .clk      (clk_int),
    .rst_n    (sys_rst_n),
    .load     (t_load),
    .clr      (t_clr),
    .dec      (t_dec),
    .load_val (t_val),
    .done     (t_done)
  );

`ifdef REFCLK_CE_IDLE_GATE_EN
  logic i_load, i_dec, i_done;

  refclk_ce_timer #(.W(CW)) u_idle_timer (
    .clk      (clk_int),
    .rst_n    (sys_rst_n),
    .load     (i_load),
    .clr      (1'b0),
    .dec      (i_dec),
    .load_val (CW'(IDLE_CYCLES)),
    .done     (i_done)
  );
`endif

  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    urst_d  = urst_q;
    gnt_d   = '0;
    fault_d = fault_q;
    t_load  = 1'b0;
    t_clr   = 1'b0;
    t_dec   = 1'b0;
    t_val   = CW'(STABLE_CYCLES - 1);
`ifdef REFCLK_CE_IDLE_GATE_EN
    i_load  = 1'b0;
    i_dec   = 1'b0;
`endif

    case (state_q)
      ST_RESET: begin
        state_d = ST_STABILIZE;
        ce_d    = 1'b0;
        urst_d  = 1'b0;
        t_load  = 1'b1;
      end
      ST_STABILIZE: begin
        t_clr = ~refclk_valid;
        if (refclk_valid && t_done) begin
          state_d = ST_ENABLE;
          ce_d    = 1'b1;
          t_load  = 1'b1;
          t_val   = CW'(RST_HOLD_CYCLES - 1);
        end else if (refclk_valid) begin
          t_dec = 1'b1;
        end
      end
      ST_ENABLE: begin
        if (t_done) begin
          state_d = ST_RUN;
          urst_d  = 1'b1;
`ifdef REFCLK_CE_IDLE_GATE_EN
          i_load  = 1'b1;
`endif
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef REFCLK_CE_IDLE_GATE_EN
        // Expiry is decided on the registered count, so a req in this cycle still gates.
        if (i_done) begin
          state_d = ST_GATED;
          ce_d    = 1'b0;
        end else begin
          gnt_d = req;
          if (|req) i_load = 1'b1;
          else      i_dec  = 1'b1;
        end
`else
        gnt_d = req;
`endif
      end
      ST_GATED: begin
        if (|req) begin
          state_d = ST_WAKE;
          ce_d    = 1'b1;
          t_load  = 1'b1;
          t_val   = CW'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKE: begin
        if (t_done) begin
          state_d = ST_RUN;
`ifdef REFCLK_CE_IDLE_GATE_EN
          i_load  = 1'b1;
`endif
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
        ce_d    = 1'b0;
        urst_d  = 1'b0;
      end
    endcase

    // Refclk loss overrides every other transition once CE has been enabled.
    if (!refclk_valid && (state_q inside {ST_ENABLE, ST_RUN, ST_GATED, ST_WAKE})) begin
      state_d = ST_STABILIZE;
      ce_d    = 1'b0;
      urst_d  = 1'b0;
      gnt_d   = '0;
      fault_d = 1'b1;
      t_load  = 1'b1;
      t_clr   = 1'b0;
      t_dec   = 1'b0;
      t_val   = CW'(STABLE_CYCLES - 1);
`ifdef REFCLK_CE_IDLE_GATE_EN
      i_load  = 1'b0;
      i_dec   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_int or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_RESET;
      ce_q    <= 1'b0;
      urst_q  <= 1'b0;
      gnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      urst_q  <= urst_d;
      gnt_q   <= gnt_d;
      fault_q <= fault_d;
    end
  end

  assign gnt        = gnt_q;
  assign bufh_ce    = ce_q;
  assign user_rst_n = urst_q;
  assign seq_state  = state_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_refclk_ce_sequencer.sv
// Self-checking bench for refclk_ce_sequencer: directed power-up / loss / gating
// scenarios followed by randomized traffic, all checked against a rule-level model.
module tb_refclk_ce_sequencer;

  localparam int unsigned NR  = 4;
  localparam int          STB = 8;
  localparam int          HLD = 4;
  localparam int          IDL = 5;
  localparam int          WK  = 2;
`ifdef REFCLK_CE_IDLE_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          refclk_valid;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic          bufh_ce;
  logic          user_rst_n;
  logic [2:0]    seq_state;
  logic          fault;

  refclk_ce_sequencer #(
    .NUM_REQ         (NR),
    .STABLE_CYCLES   (STB),
    .RST_HOLD_CYCLES (HLD),
    .IDLE_CYCLES     (IDL),
    .WAKE_CYCLES     (WK)
  ) dut (
    .clk_int      (clk),
    .sys_rst_n    (sys_rst_n),
    .refclk_valid (refclk_valid),
    .req          (req),
    .gnt          (gnt),
    .bufh_ce      (bufh_ce),
    .user_rst_n   (user_rst_n),
    .seq_state    (seq_state),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: phase number plus elapsed-cycle counts, advanced by the behavioural rules.
  typedef struct {
    int          st;
    int          stab;
    int          hold;
    int          idle;
    int          wk;
    bit          ce;
    bit          ur;
    bit          fault;
    logic [3:0]  gnt;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t nxt(input model_t c, input logic v, input logic [3:0] r);
    model_t n;
    n = c;
    n.gnt = '0;
    if (!v && c.st >= 2) begin
      n.st = 1; n.ce = 0; n.ur = 0; n.fault = 1; n.stab = 0;
      return n;
    end
    case (c.st)
      0: begin n.st = 1; n.stab = 0; end
      1: begin
        if (!v) n.stab = 0;
        else if (c.stab == STB - 1) begin n.st = 2; n.ce = 1; n.hold = 0; end
        else n.stab = c.stab + 1;
      end
      2: begin
        n.hold = c.hold + 1;
        if (n.hold == HLD) begin n.st = 3; n.ur = 1; n.idle = 0; end
      end
      3: begin
        if (GATE && c.idle == IDL) begin
          n.st = 4; n.ce = 0;
        end else begin
          n.gnt  = r;
          n.idle = (r != 0) ? 0 : ((c.idle < IDL) ? c.idle + 1 : IDL);
        end
      end
      4: if (r != 0) begin n.st = 5; n.ce = 1; n.wk = 0; end
      5: begin
        n.wk = c.wk + 1;
        if (n.wk == WK) begin n.st = 3; n.idle = 0; end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= '{default: 0};
    else            m <= nxt(m, refclk_valid, req);
  end

  always @(negedge clk) begin
    if (cmp_en)
      chk("cycle {gnt,ce,urst,state,fault}",
          {22'd0, gnt, bufh_ce, user_rst_n, seq_state, fault},
          {22'd0, m.gnt, m.ce, m.ur, 3'(m.st), m.fault});
  end

  task automatic cyc(input logic v, input logic [3:0] r);
    refclk_valid = v;
    req          = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit idle_phase;
    sys_rst_n    = 1'b0;
    refclk_valid = 1'b1;
    req          = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_outputs", {gnt, bufh_ce, user_rst_n, seq_state, fault}, '0);
    #2 sys_rst_n = 1'b1;

    // Power-up with a steady reference clock.
    for (int k = 1; k <= 13; k++) begin
      cyc(1'b1, 4'b0000);
      if (k == 1)  chk("pu_stabilize", seq_state, 3'd1);
      if (k == 8)  chk("pu_ce_still_low", bufh_ce, 1'b0);
      if (k == 9) begin
        chk("pu_ce_rise", {seq_state, bufh_ce, user_rst_n}, {3'd2, 1'b1, 1'b0});
        chk("model_ce_rise", m.ce, 1'b1);
      end
      if (k == 12) chk("pu_rst_held", user_rst_n, 1'b0);
      if (k == 13) begin
        chk("pu_run", {seq_state, user_rst_n}, {3'd3, 1'b1});
        chk("model_run", m.st, 3);
      end
    end

    // Grant delay then refclk loss in RUN.
    cyc(1'b1, 4'b0011);
    chk("gnt_delay", gnt, 4'b0011);
    cyc(1'b0, 4'b0011);
    chk("refclk_loss", {gnt, bufh_ce, user_rst_n, seq_state, fault},
        {4'b0000, 1'b0, 1'b0, 3'd1, 1'b1});

    // Stability glitch after 6 valid cycles restarts the count.
    repeat (6) cyc(1'b1, 4'b0000);
    cyc(1'b0, 4'b0000);
    repeat (7) cyc(1'b1, 4'b0000);
    chk("glitch_ce_low", {seq_state, bufh_ce}, {3'd1, 1'b0});
    cyc(1'b1, 4'b0000);
    chk("glitch_ce_rise", bufh_ce, 1'b1);
    repeat (4) cyc(1'b1, 4'b0000);
    chk("rerun_fault_sticky", {seq_state, user_rst_n, fault}, {3'd3, 1'b1, 1'b1});

`ifdef REFCLK_CE_IDLE_GATE_EN
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b0101);
      chk("grant_0101", gnt, 4'b0101);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 4'b0000);
      if (i == 1) chk("grant_drop", gnt, 4'b0000);
      if (i == 5) chk("idle_not_yet", {seq_state, bufh_ce}, {3'd3, 1'b1});
    end
    cyc(1'b1, 4'b0000);
    chk("gated", {gnt, bufh_ce, user_rst_n, seq_state}, {4'b0000, 1'b0, 1'b1, 3'd4});
    chk("model_gated", m.st, 4);
    cyc(1'b1, 4'b1000);
    chk("wake1", {gnt, bufh_ce, seq_state}, {4'b0000, 1'b1, 3'd5});
    cyc(1'b1, 4'b1000);
    chk("wake2", {gnt, bufh_ce, seq_state}, {4'b0000, 1'b1, 3'd5});
    cyc(1'b1, 4'b1000);
    chk("wake_run", {gnt, seq_state}, {4'b0000, 3'd3});
    cyc(1'b1, 4'b1000);
    chk("wake_gnt", gnt, 4'b1000);
    // Req arriving in the expiry cycle: gating wins, then wakes.
    repeat (5) cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0001);
    chk("expiry_vs_req", {seq_state, bufh_ce}, {3'd4, 1'b0});
    cyc(1'b1, 4'b0001);
    chk("expiry_wake", seq_state, 3'd5);
`else
    repeat (100) cyc(1'b1, 4'b0000);
    chk("no_gate_run", {seq_state, bufh_ce, gnt}, {3'd3, 1'b1, 4'b0000});
`endif

    // Asynchronous reset asserted between clock edges.
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_reset", {gnt, bufh_ce, user_rst_n, seq_state, fault}, '0);
    @(posedge clk);
    #3 sys_rst_n = 1'b1;

    // Randomized traffic: bursty requests, occasional refclk drops.
    idle_phase = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) idle_phase = ~idle_phase;
      cyc(($urandom_range(0, 59) != 0),
          idle_phase ? 4'b0000 : 4'($urandom_range(0, 15)));
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
